// File: rtl/aes_round_scheduler.sv
// ============================================================================
// Module   : aes_round_scheduler
// Purpose  : Arbitrates enc/dec requests onto a shared AES round datapath and
//            sequences the KEY/ADD/SUB/SHIFT/MIX step pulses with round index.
// Options  : AES_ROUND_TIMEOUT_EN adds a per-step 8-bit watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module aes_round_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       enc_req,
    input  logic       dec_req,
    input  logic       step_done,
    output logic       enc_gnt,
    output logic       dec_gnt,
    output logic       key_start,
    output logic       add_start,
    output logic       sub_start,
    output logic       shift_start,
    output logic       mix_start,
    output logic       mode,
    output logic [3:0] round,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEY    = 3'd1,
        S_ADD    = 3'd2,
        S_SUB    = 3'd3,
        S_SHIFT  = 3'd4,
        S_MIX    = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    localparam logic [3:0] C_FIRST_ROUND = 4'd0;
    localparam logic [3:0] C_LAST_ROUND  = 4'd10;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_round_next;
    logic       r_dec_prio;
    logic       w_pulse;
    logic       w_in_step;
    logic       w_adv;
    logic       w_expire;

    assign w_pulse   = key_start | add_start | sub_start | shift_start | mix_start;
    assign w_in_step = (r_state != S_IDLE) && (r_state != S_FINISH);
    // The start-pulse cycle never counts as completion of the new step.
    assign w_adv     = w_in_step && !w_pulse && step_done;

    always_comb begin
        w_next       = r_state;
        w_round_next = round;
        case (r_state)
            S_KEY: w_next = S_ADD;
            S_ADD: begin
                if (!mode)
                    w_next = (round == C_LAST_ROUND) ? S_FINISH : S_SUB;
                else if (round == C_FIRST_ROUND)
                    w_next = S_FINISH;
                else
                    w_next = (round == C_LAST_ROUND) ? S_SHIFT : S_MIX;
            end
            S_SUB: begin
                // Round index moves when leaving SUB, saturating at the ends.
                if (!mode) begin
                    w_next = S_SHIFT;
                    if (round != C_LAST_ROUND)
                        w_round_next = round + 4'd1;
                end else begin
                    w_next = S_ADD;
                    if (round != C_FIRST_ROUND)
                        w_round_next = round - 4'd1;
                end
            end
            S_SHIFT: begin
                if (!mode)
                    w_next = (round == C_LAST_ROUND) ? S_ADD : S_MIX;
                else
                    w_next = S_SUB;
            end
            S_MIX: w_next = mode ? S_SHIFT : S_ADD;
            default: w_next = r_state;
        endcase
    end

`ifdef AES_ROUND_TIMEOUT_EN
    localparam logic [7:0] C_WD_LAST = 8'd254;

    logic [7:0] r_wd;
    logic       r_error;

    // Counter reads 0 in a step's pulse cycle, so expiry lands 255 cycles later.
    assign w_expire = w_in_step && !w_adv && (r_wd == C_WD_LAST);
    assign error    = r_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd    <= 8'd0;
            r_error <= 1'b0;
        end else begin
            r_error <= w_expire;
            if (!w_in_step || w_adv || w_expire)
                r_wd <= 8'd0;
            else
                r_wd <= r_wd + 8'd1;
        end
    end
`else
    assign w_expire = 1'b0;
    assign error    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dec_prio  <= 1'b0;
            enc_gnt     <= 1'b0;
            dec_gnt     <= 1'b0;
            key_start   <= 1'b0;
            add_start   <= 1'b0;
            sub_start   <= 1'b0;
            shift_start <= 1'b0;
            mix_start   <= 1'b0;
            mode        <= 1'b0;
            round       <= C_FIRST_ROUND;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            key_start   <= 1'b0;
            add_start   <= 1'b0;
            sub_start   <= 1'b0;
            shift_start <= 1'b0;
            mix_start   <= 1'b0;
            done        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enc_req && (!dec_req || !r_dec_prio)) begin
                        r_state    <= S_KEY;
                        enc_gnt    <= 1'b1;
                        mode       <= 1'b0;
                        round      <= C_FIRST_ROUND;
                        busy       <= 1'b1;
                        key_start  <= 1'b1;
                        r_dec_prio <= 1'b1;
                    end else if (dec_req) begin
                        r_state    <= S_KEY;
                        dec_gnt    <= 1'b1;
                        mode       <= 1'b1;
                        round      <= C_LAST_ROUND;
                        busy       <= 1'b1;
                        key_start  <= 1'b1;
                        r_dec_prio <= 1'b0;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    enc_gnt <= 1'b0;
                    dec_gnt <= 1'b0;
                    busy    <= 1'b0;
                    mode    <= 1'b0;
                    round   <= C_FIRST_ROUND;
                end
                default: begin
                    if (w_adv) begin
                        r_state <= w_next;
                        round   <= w_round_next;
                        case (w_next)
                            S_ADD:    add_start   <= 1'b1;
                            S_SUB:    sub_start   <= 1'b1;
                            S_SHIFT:  shift_start <= 1'b1;
                            S_MIX:    mix_start   <= 1'b1;
                            S_FINISH: done        <= 1'b1;
                            default:  ;
                        endcase
                    end else if (w_expire) begin
                        r_state <= S_IDLE;
                        enc_gnt <= 1'b0;
                        dec_gnt <= 1'b0;
                        busy    <= 1'b0;
                        mode    <= 1'b0;
                        round   <= C_FIRST_ROUND;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_round_scheduler.sv
// ============================================================================
// Module   : tb_aes_round_scheduler
// Purpose  : Randomized self-checking bench for aes_round_scheduler against a
//            step-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aes_round_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enc_req = 1'b0;
    logic       dec_req = 1'b0;
    logic       step_done = 1'b0;
    logic       enc_gnt, dec_gnt;
    logic       key_start, add_start, sub_start, shift_start, mix_start;
    logic       mode, busy, done, error;
    logic [3:0] round;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    aes_round_scheduler u_dut (
        .clk         (clk),
        .reset       (reset),
        .enc_req     (enc_req),
        .dec_req     (dec_req),
        .step_done   (step_done),
        .enc_gnt     (enc_gnt),
        .dec_gnt     (dec_gnt),
        .key_start   (key_start),
        .add_start   (add_start),
        .sub_start   (sub_start),
        .shift_start (shift_start),
        .mix_start   (mix_start),
        .mode        (mode),
        .round       (round),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Step codes: 1 KEY, 2 ADD, 3 SUB, 4 SHIFT, 5 MIX; entries are code*16+round.
    task automatic build_expected(input bit inv);
        exp_q.delete();
        if (!inv) begin
            exp_q.push_back(1*16 + 0);
            exp_q.push_back(2*16 + 0);
            for (int r = 1; r <= 10; r++) begin
                exp_q.push_back(3*16 + r - 1);
                exp_q.push_back(4*16 + r);
                if (r < 10) exp_q.push_back(5*16 + r);
                exp_q.push_back(2*16 + r);
            end
        end else begin
            exp_q.push_back(1*16 + 10);
            exp_q.push_back(2*16 + 10);
            for (int r = 9; r >= 0; r--) begin
                exp_q.push_back(4*16 + r + 1);
                exp_q.push_back(3*16 + r + 1);
                exp_q.push_back(2*16 + r);
                if (r > 0) exp_q.push_back(5*16 + r);
            end
        end
    endtask

    function automatic int pulse_code();
        int n = 0;
        int c = 0;
        if (key_start)   begin n++; c = 1; end
        if (add_start)   begin n++; c = 2; end
        if (sub_start)   begin n++; c = 3; end
        if (shift_start) begin n++; c = 4; end
        if (mix_start)   begin n++; c = 5; end
        return (n > 1) ? 99 : c;
    endfunction

    function automatic int outs_vec();
        return int'({enc_gnt, dec_gnt, key_start, add_start, sub_start, shift_start,
                     mix_start, mode, busy, done, error, round});
    endfunction

    // Caller raises the request #1 after an edge; grant's KEY pulse is expected next cycle.
    task automatic run_op(input bit inv, input int lat_lo, input int lat_hi,
                          input bit coincident, input bit drop_req, input bit keep_req);
        int idx = 0, cnt = 0, last_pc = 0, exp_gap = 0, gap_bad = 0, side_bad = 0;
        int done_cnt = 0, pc, lat;
        int npulse[6];
        string nm;
        nm = inv ? "dec" : "enc";
        foreach (npulse[i]) npulse[i] = 0;
        build_expected(inv);
        for (int cyc = 0; cyc < 3000 && done_cnt == 0; cyc++) begin
            @(posedge clk); #1;
            step_done = 1'b0;
            if (enc_gnt && dec_gnt) side_bad++;
            pc = pulse_code();
            if (pc != 0) begin
                if (idx == 0) check_val({nm, "_grant_latency"}, cyc, 0);
                if (idx < exp_q.size())
                    check_val($sformatf("%s_seq%0d", nm, idx), pc*16 + int'(round), exp_q[idx]);
                else
                    check_val({nm, "_extra_pulse"}, pc, 0);
                if (idx > 0 && (cyc - last_pc) != exp_gap) gap_bad++;
                if (mode != inv || !busy || enc_gnt != !inv || dec_gnt != inv) side_bad++;
                if (pc < 6) npulse[pc]++;
                lat     = $urandom_range(lat_hi, lat_lo);
                exp_gap = lat + 1;
                cnt     = lat;
                last_pc = cyc;
                if (coincident) step_done = 1'b1;
                idx++;
                if (drop_req && idx == 3) begin enc_req = 1'b0; dec_req = 1'b0; end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) step_done = 1'b1;
            end
            if (done) begin
                done_cnt++;
                if ((cyc - last_pc) != exp_gap) gap_bad++;
                if (mode != inv || !busy || enc_gnt != !inv || dec_gnt != inv) side_bad++;
                if (!keep_req) begin enc_req = 1'b0; dec_req = 1'b0; end
            end
        end
        check_val({nm, "_done_count"}, done_cnt, 1);
        check_val({nm, "_pulse_total"}, idx, 41);
        check_val({nm, "_key_pulses"}, npulse[1], 1);
        check_val({nm, "_add_pulses"}, npulse[2], 11);
        check_val({nm, "_sub_pulses"}, npulse[3], 10);
        check_val({nm, "_shift_pulses"}, npulse[4], 10);
        check_val({nm, "_mix_pulses"}, npulse[5], 9);
        check_val({nm, "_step_timing_errs"}, gap_bad, 0);
        check_val({nm, "_grant_mode_errs"}, side_bad, 0);
        @(posedge clk); #1;
        step_done = 1'b0;
        check_val({nm, "_post_done_idle"},
                  int'({busy, enc_gnt, dec_gnt, mode, done, error}), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; enc_req = 1'b0; dec_req = 1'b0; step_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs", outs_vec(), 0);
        reset = 1'b0; step_done = 1'b0;
    endtask

    task automatic reset_mid_op();
        bit hit = 1'b0;
        int dones = 0;
        enc_req = 1'b1;
        step_done = 1'b1;
        for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (pulse_code() != 0 && round == 4'd5) begin
                hit = 1'b1; reset = 1'b1; enc_req = 1'b0;
            end
        end
        check_val("round5_reached", int'(hit), 1);
        @(posedge clk); #1;
        check_val("midop_reset_outputs", outs_vec(), 0);
        reset = 1'b0; step_done = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done || error || busy) dones++;
        end
        check_val("midop_no_done_after", dones, 0);
    endtask

    task automatic timeout_test();
        int np = 0, third = -1, err_cyc = -1, err_hold = -1, err_cnt = 0, dones = 0;
        enc_req = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            step_done = 1'b0;
            if (pulse_code() != 0) begin
                np++;
                if (np == 1) enc_req = 1'b0;
                if (np == 3) third = cyc;
            end else if (np < 3) step_done = 1'b1;
            if (done) dones++;
            if (error) begin
                err_cnt++;
                if (err_cyc < 0) begin
                    err_cyc  = cyc;
                    err_hold = int'({enc_gnt, dec_gnt, busy});
                end
            end
        end
        check_val("to_pulses_before_stall", np, 3);
        check_val("to_no_done", dones, 0);
`ifdef AES_ROUND_TIMEOUT_EN
        check_val("to_error_delay", err_cyc - third, 255);
        check_val("to_error_pulses", err_cnt, 1);
        check_val("to_grant_released", err_hold, 0);
`else
        check_val("to_error_pulses", err_cnt, 0);
        check_val("to_busy_held", int'(busy), 1);
`endif
    endtask

    initial begin
        do_reset();

        enc_req = 1'b1;
        run_op(1'b0, 1, 1, 1'b0, 1'b0, 1'b0);

        dec_req = 1'b1;
        run_op(1'b1, 3, 3, 1'b0, 1'b0, 1'b0);

        do_reset();
        enc_req = 1'b1; dec_req = 1'b1;
        run_op(1'b0, 1, 2, 1'b0, 1'b0, 1'b1);
        run_op(1'b1, 1, 2, 1'b0, 1'b0, 1'b0);

        enc_req = 1'b1;
        run_op(1'b0, 2, 3, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            bit inv;
            inv = 1'($urandom_range(1, 0));
            if (inv) dec_req = 1'b1; else enc_req = 1'b1;
            run_op(inv, 1, 4, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0);
        end

        reset_mid_op();
        enc_req = 1'b1;
        run_op(1'b0, 1, 1, 1'b0, 1'b0, 1'b0);

        timeout_test();
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
